fft_twiddle_sequencer: RTL and testbench
========================================

// Module: fft_twiddle_sequencer
// PURPOSE
//  Address/twiddle sequencer for the in-place radix-2 DIT 1024-point FFT. On Start it walks
//  all LOG2N stages x N/2 butterflies. For each butterfly it issues the operand addresses and
//  the twiddle index n to FFT1024_LUT, over a valid/ready handshake to the butterfly unit.
//  Between stages it waits for the butterfly pipeline to drain, which avoids read-after-write
//  hazards on the shared sample RAM.
// PARAMETERS
//  LOG2N   10   log2 of FFT size; N=1024, N/2=512 butterflies per stage
//  TW_W    10   width of twiddle index bus, matches LUT port n
// PORTS
//  Clk        in   1        system clock, all state changes on rising edge
//  Reset      in   1        synchronous reset, active-low
//  Start      in   1        1-cycle request to begin a transform; honoured only in IDLE
//  bf_ready   in   1        butterfly unit accepts current beat
//  bf_idle    in   1        butterfly pipeline empty, all writes retired
//  bf_valid   out  1        addr_a/addr_b/tw_n/stage valid this cycle
//  addr_a     out  LOG2N    top operand address
//  addr_b     out  LOG2N    bottom operand address (= addr_a + 2^stage)
//  tw_n       out  TW_W     twiddle index to FFT1024_LUT.n; MSB always 0 (range 0..511)
//  stage      out  4        current stage 0..LOG2N-1
//  busy       out  1        high from Start acceptance until done cycle (exclusive)
//  done       out  1        1-cycle pulse at transform completion
// BEHAVIOUR
//  Reset (Reset==0 at edge): state=IDLE; all outputs 0; counters cleared. Overrides Start.
//   Mid-transform reset aborts with no done pulse.
//  FSM: IDLE -> RUN (Start==1) ; RUN -> DRAIN (last beat of stage accepted) ;
//   DRAIN -> RUN (bf_idle==1, stage<LOG2N-1; stage++, b=0) ;
//   DRAIN -> DONE (bf_idle==1, stage==LOG2N-1) ; DONE -> IDLE (unconditional, 1 cycle).
//  Beat math, registered, for stage s and butterfly counter b (0..N/2-1):
//   half=1<<s; j=b&(half-1); grp=b>>s; addr_a=(grp<<(s+1))|j; addr_b=addr_a+half;
//   tw_n=j<<(LOG2N-1-s). No arithmetic overflow: addr_b <= N-1 by construction.
//  Latency: Start sampled at edge k -> bf_valid=1 with b=0,s=0 after edge k+1.
//  Handshake: beat transfers when bf_valid&&bf_ready. While bf_valid&&!bf_ready, all outputs
//   hold stable; bf_valid never drops without a transfer. b increments only on transfer.
//  bf_valid=1 only in RUN. In DRAIN, DONE and IDLE it is 0; outputs keep their last value
//   except in IDLE after reset.
//  Stage boundary: at least 1 bubble cycle (DRAIN) per stage, more while bf_idle==0.
//  done=1 only in DONE; busy=1 in RUN and DRAIN; busy=0 in the DONE cycle.
//  Start while busy or in DONE: ignored, no queuing.
//  b wrap: the transfer at b=511 moves to DRAIN; b resets to 0 on re-entry to RUN.
// TESTING
//  1 Start, bf_ready=bf_idle=1 -> first beats (s0) a/b/tw = 0/1/0, 2/3/0; s1 beat1: 1/3/256;
//     s9 beat1: 1/513/1; s9 last: 511/1023/511.
//  2 Same as 1 -> exactly 5120 transfers; done pulses once, 5131 cycles after Start edge; busy
//     then low.
//  3 bf_ready=0 for 3 cycles at s0 beat5 -> addr_a=10, addr_b=11, tw_n=0 held; next transfer is
//     beat 6 (12/13/0); no beat lost or duplicated.
//  4 bf_idle=0 for 4 cycles after last s0 beat -> bf_valid=0 and stage=0 for 4+ cycles; then
//     s1 beat0 = 0/2/0.
//  5 Start pulsed during s2 -> ignored; sequence and transfer count unchanged.
//  6 Reset=0 during s3 -> next cycle all outputs 0, no done. Reset=0 with Start=1 -> stays IDLE.
//     A fresh Start then restarts at s0 beat0.

Source files
------------

// File: rtl/fft_twiddle_sequencer.sv
// Operand-address and twiddle-index sequencer for an in-place radix-2 DIT FFT.
// Walks LOG2N stages of N/2 butterflies over a valid/ready link and drains between stages.
module fft_twiddle_sequencer #(
    parameter int LOG2N = 10,
    parameter int TW_W  = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             bf_ready,
    input  logic             bf_idle,
    output logic             bf_valid,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [TW_W-1:0]  tw_n,
    output logic [3:0]       stage,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [LOG2N-2:0] B_ZERO = {(LOG2N-1){1'b0}};
    localparam logic [LOG2N-2:0] B_ONE  = {{(LOG2N-2){1'b0}}, 1'b1};
    localparam logic [LOG2N-2:0] B_LAST = {(LOG2N-1){1'b1}};
    localparam logic [3:0]       S_LAST = 4'(LOG2N-1);

    // Bits below the stage position select the element inside a group.
    function automatic logic [LOG2N-1:0] beat_mask(input logic [3:0] s);
        return (LOG2N'(1) << s) - LOG2N'(1);
    endfunction

    // Insert a zero at bit position s of the butterfly counter.
    function automatic logic [LOG2N-1:0] beat_addr_a(input logic [LOG2N-2:0] b, input logic [3:0] s);
        logic [LOG2N-1:0] bw;
        logic [LOG2N-1:0] m;
        bw = {1'b0, b};
        m  = beat_mask(s);
        return ((bw & ~m) << 1'b1) | (bw & m);
    endfunction

    function automatic logic [TW_W-1:0] beat_tw(input logic [LOG2N-2:0] b, input logic [3:0] s);
        logic [LOG2N-1:0] bw;
        bw = {1'b0, b};
        return TW_W'((bw & beat_mask(s)) << (4'(LOG2N-1) - s));
    endfunction

    state_t           state_q, state_d;
    logic [LOG2N-2:0] b_q, b_d;
    logic [3:0]       stage_q, stage_d;
    logic             valid_q, valid_d;
    logic [LOG2N-1:0] addr_a_q, addr_a_d;
    logic [LOG2N-1:0] addr_b_q, addr_b_d;
    logic [TW_W-1:0]  tw_q, tw_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ld_en_s;
    logic [LOG2N-2:0] ld_b_s;
    logic [3:0]       ld_s_s;

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            b_q      <= B_ZERO;
            stage_q  <= 4'd0;
            valid_q  <= 1'b0;
            addr_a_q <= {LOG2N{1'b0}};
            addr_b_q <= {LOG2N{1'b0}};
            tw_q     <= {TW_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            stage_q  <= stage_d;
            valid_q  <= valid_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; a beat is loaded into the output registers whenever ld_en_s is set.
    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        stage_d  = stage_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ld_en_s  = 1'b0;
        ld_b_s   = b_q;
        ld_s_s   = stage_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        tw_d     = tw_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    b_d     = B_ZERO;
                    stage_d = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!valid_q) begin
                    ld_en_s = 1'b1;
                    valid_d = 1'b1;
                end else if (bf_ready) begin
                    if (b_q == B_LAST) begin
                        state_d = ST_DRAIN;
                        valid_d = 1'b0;
                    end else begin
                        b_d     = b_q + B_ONE;
                        ld_b_s  = b_q + B_ONE;
                        ld_en_s = 1'b1;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (bf_idle) begin
                    if (stage_q == S_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                        stage_d = stage_q + 4'd1;
                        b_d     = B_ZERO;
                        valid_d = 1'b1;
                        ld_b_s  = B_ZERO;
                        ld_s_s  = stage_q + 4'd1;
                        ld_en_s = 1'b1;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (ld_en_s) begin
            addr_a_d = beat_addr_a(ld_b_s, ld_s_s);
            addr_b_d = beat_addr_a(ld_b_s, ld_s_s) + (LOG2N'(1) << ld_s_s);
            tw_d     = beat_tw(ld_b_s, ld_s_s);
        end else begin
            addr_a_d = addr_a_q;
        end
    end

    assign bf_valid = valid_q;
    assign addr_a   = addr_a_q;
    assign addr_b   = addr_b_q;
    assign tw_n     = tw_q;
    assign stage    = stage_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Randomized bench for fft_twiddle_sequencer: every accepted beat is compared with the
// butterfly index arithmetic computed directly from the transfer number.
module tb_fft_twiddle_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       bf_ready;
    logic       bf_idle;
    logic       bf_valid;
    logic [9:0] addr_a;
    logic [9:0] addr_b;
    logic [9:0] tw_n;
    logic [3:0] stage;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    fft_twiddle_sequencer #(.LOG2N(10), .TW_W(10)) dut (
        .Clk      (clk),
        .Reset    (rst_n),
        .Start    (start),
        .bf_ready (bf_ready),
        .bf_idle  (bf_idle),
        .bf_valid (bf_valid),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .tw_n     (tw_n),
        .stage    (stage),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: transfer number idx -> stage idx/512, butterfly idx%512.
    task automatic exp_beat(input int idx, output int ea, output int eb, output int et, output int es);
        int s;
        int b;
        int half;
        int j;
        int grp;
        s    = idx / 512;
        b    = idx % 512;
        half = 2 ** s;
        j    = b % half;
        grp  = b / half;
        ea   = grp * 2 * half + j;
        eb   = ea + half;
        et   = j * (512 / half);
        es   = s;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_valid"}, int'(bf_valid), 0);
        chk_eq({tag, "_addr_a"}, int'(addr_a), 0);
        chk_eq({tag, "_addr_b"}, int'(addr_b), 0);
        chk_eq({tag, "_tw"}, int'(tw_n), 0);
        chk_eq({tag, "_stage"}, int'(stage), 0);
        chk_eq({tag, "_busy"}, int'(busy), 0);
        chk_eq({tag, "_done"}, int'(done), 0);
    endtask

    // One transform; called and returning at a negedge. abort_at>0 resets after that many transfers.
    task automatic run_xfer(input int rdy_pct, input int idle_pct, input int abort_at, input bit full_speed);
        int  idx;
        int  n;
        int  ea, eb, et, es;
        bit  rdy;
        bit  prev_stall;
        bit  first_seen;
        idx        = 0;
        n          = 0;
        prev_stall = 1'b0;
        first_seen = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        forever begin
            if (done) begin
                chk_eq("done_busy", int'(busy), 0);
                chk_eq("done_valid", int'(bf_valid), 0);
                chk_eq("transfers", idx, 5120);
                if (full_speed) chk_eq("done_latency", n, 5131);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk_eq("idle_busy", int'(busy), 0);
                chk_eq("idle_done", int'(done), 0);
                @(negedge clk);
                chk_eq("no_queue_busy", int'(busy), 0);
                chk_eq("no_queue_valid", int'(bf_valid), 0);
                return;
            end
            if (abort_at > 0 && idx >= abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk_all_zero("abort");
                @(negedge clk);
                chk_eq("abort_idle_busy", int'(busy), 0);
                chk_eq("abort_idle_done", int'(done), 0);
                return;
            end
            chk_eq("busy", int'(busy), 1);
            if (prev_stall) chk_eq("valid_hold", int'(bf_valid), 1);
            if (bf_valid) begin
                if (!first_seen && full_speed) chk_eq("first_latency", n, 1);
                first_seen = 1'b1;
                exp_beat(idx, ea, eb, et, es);
                chk_eq("addr_a", int'(addr_a), ea);
                chk_eq("addr_b", int'(addr_b), eb);
                chk_eq("tw_n", int'(tw_n), et);
                chk_eq("stage", int'(stage), es);
            end
            rdy      = ($urandom_range(99) < rdy_pct);
            bf_ready = rdy;
            bf_idle  = ($urandom_range(99) < idle_pct);
            start    = ($urandom_range(99) < 2);
            if (bf_valid && rdy) idx++;
            prev_stall = bf_valid && !rdy;
            if (n > 40000) begin
                chk_eq("timeout", 1, 0);
                start = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        bf_ready = 1'b0;
        bf_idle  = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("post_reset_busy", int'(busy), 0);

        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        chk_all_zero("reset_start");
        @(negedge clk);
        chk_eq("reset_start_busy", int'(busy), 0);

        run_xfer(100, 100, 0, 1'b1);
        run_xfer(60, 70, 0, 1'b0);
        run_xfer(85, 40, 0, 1'b0);
        run_xfer(75, 80, 3 * 512 + int'($urandom_range(0, 300)), 1'b0);
        run_xfer(100, 100, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
